// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan: registered N-to-1 channel multiplexer with a valid/ready output
// stage. The channel is chosen either by an explicit select code (direct mode)
// or by a round-robin scan pointer that skips idle channels (scan mode).
// A captured channel is told so by a one-cycle one-hot pulse on o_ack.
// Optional build macro MUX_N_1_SCAN_PARITY_EN adds o_parity, the XOR of the
// captured data word, registered alongside o_f.

module mux_n_1_scan #(
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_CH*DATA_W-1:0]   i_code,
    input  logic [N_CH-1:0]          i_valid,
    input  logic                     i_mode,
    input  logic [SEL_W-1:0]         i_sel_code,
    input  logic                     i_ready,
    output logic [DATA_W-1:0]        o_f,
    output logic                     o_valid,
    output logic [SEL_W-1:0]         o_ch,
    output logic [N_CH-1:0]          o_ack,
    output logic                     o_sel_err
`ifdef MUX_N_1_SCAN_PARITY_EN
    ,
    output logic                     o_parity
`endif
);

    localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH-1);

    logic [SEL_W-1:0]      ptr;
    logic                  mode_q;
    logic [SEL_W-1:0]      eff_ptr;
    logic [2**SEL_W-1:0]   valid_ext;
    logic                  sel_ok;
    logic [SEL_W:0]        probe;
    logic                  scan_found;
    logic [SEL_W-1:0]      scan_idx;
    logic                  cand_found;
    logic [SEL_W-1:0]      cand_idx;
    logic [DATA_W-1:0]     cand_data;
    logic [N_CH-1:0]       cand_onehot;
    logic [SEL_W-1:0]      next_ptr;
    logic                  space;
    logic                  capture;

    // Entering scan mode restarts the search at channel 0 for that one cycle.
    assign eff_ptr = (i_mode && !mode_q) ? '0 : ptr;
    assign sel_ok  = ({1'b0, i_sel_code} < N_CH_L);
    assign space   = !o_valid || i_ready;
    assign capture = space && cand_found;
    assign next_ptr = (cand_idx == LAST_CH) ? '0 : cand_idx + SEL_W'(1);

    // Pad the valid vector to the full select range so any code indexes safely.
    always_comb begin
        valid_ext = '0;
        valid_ext[N_CH-1:0] = i_valid;
    end

    // Round-robin search: first valid channel at or after the pointer, wrapping.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        probe      = '0;
        for (int j = 0; j < N_CH; j++) begin
            probe = {1'b0, eff_ptr} + (SEL_W+1)'(j);
            if (probe >= N_CH_L)
                probe = probe - N_CH_L;
            if (!scan_found && valid_ext[probe[SEL_W-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = probe[SEL_W-1:0];
            end
        end
    end

    // Pick the candidate channel for the active mode and gather its data/ack.
    always_comb begin
        if (i_mode) begin
            cand_found = scan_found;
            cand_idx   = scan_idx;
        end else begin
            cand_found = sel_ok && valid_ext[i_sel_code];
            cand_idx   = i_sel_code;
        end
        cand_data   = '0;
        cand_onehot = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (SEL_W'(c) == cand_idx) begin
                cand_data      = i_code[c*DATA_W +: DATA_W];
                cand_onehot[c] = 1'b1;
            end
        end
    end

    // Output register stage, scan pointer and mode history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_f       <= '0;
            o_valid   <= 1'b0;
            o_ch      <= '0;
            o_ack     <= '0;
            o_sel_err <= 1'b0;
            ptr       <= '0;
            mode_q    <= 1'b0;
        end else begin
            mode_q    <= i_mode;
            o_sel_err <= !i_mode && !sel_ok;
            o_ack     <= '0;
            if (capture) begin
                o_f     <= cand_data;
                o_ch    <= cand_idx;
                o_valid <= 1'b1;
                o_ack   <= cand_onehot;
                if (i_mode)
                    ptr <= next_ptr;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_N_1_SCAN_PARITY_EN
    // Parity of the captured word follows o_f exactly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_parity <= 1'b0;
        else if (capture)
            o_parity <= ^cand_data;
    end
`endif

endmodule

// File: tb/tb_mux_n_1_scan.sv
module tb_mux_n_1_scan;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    // 8-channel instance
    logic [63:0] code8;
    logic [7:0]  valid8;
    logic        mode8;
    logic [2:0]  sel8;
    logic        ready8;
    logic [7:0]  f8;
    logic        vo8;
    logic [2:0]  ch8;
    logic [7:0]  ack8;
    logic        err8;
    logic [19:0] obs8;
    assign obs8 = {vo8, ch8, f8, ack8};

    // 6-channel instance (select codes 6 and 7 are out of range)
    logic [47:0] code6;
    logic [5:0]  valid6;
    logic        mode6;
    logic [2:0]  sel6;
    logic        ready6;
    logic [7:0]  f6;
    logic        vo6;
    logic [2:0]  ch6;
    logic [5:0]  ack6;
    logic        err6;
    logic [17:0] obs6;
    assign obs6 = {vo6, ch6, f6, ack6};

`ifdef MUX_N_1_SCAN_PARITY_EN
    logic par8, par6;
`endif

    mux_n_1_scan #(.N_CH(8), .SEL_W(3), .DATA_W(8)) u8 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(code8), .i_valid(valid8),
        .i_mode(mode8), .i_sel_code(sel8), .i_ready(ready8),
        .o_f(f8), .o_valid(vo8), .o_ch(ch8), .o_ack(ack8), .o_sel_err(err8)
`ifdef MUX_N_1_SCAN_PARITY_EN
        , .o_parity(par8)
`endif
    );

    mux_n_1_scan #(.N_CH(6), .SEL_W(3), .DATA_W(8)) u6 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(code6), .i_valid(valid6),
        .i_mode(mode6), .i_sel_code(sel6), .i_ready(ready6),
        .o_f(f6), .o_valid(vo6), .o_ch(ch6), .o_ack(ack6), .o_sel_err(err6)
`ifdef MUX_N_1_SCAN_PARITY_EN
        , .o_parity(par6)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        code8 = '0; valid8 = '0; mode8 = 1'b0; sel8 = '0; ready8 = 1'b1;
        code6 = '0; valid6 = '0; mode6 = 1'b0; sel6 = '0; ready6 = 1'b1;
        #12;
        checks++;
        if ({obs8, err8} !== 21'h0) begin
            failures++;
            $display("FAIL reset8 got=%h exp=0", {obs8, err8});
        end
        checks++;
        if ({obs6, err6} !== 19'h0) begin
            failures++;
            $display("FAIL reset6 got=%h exp=0", {obs6, err6});
        end
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic test_direct();
        code8[2*8 +: 8] = 8'h5A;
        valid8 = 8'h04; sel8 = 3'd2; mode8 = 1'b0; ready8 = 1'b1;
        step();
        checks++;
        if (obs8 !== {1'b1, 3'd2, 8'h5A, 8'h04}) begin
            failures++;
            $display("FAIL direct_capture got=%h exp=%h", obs8, {1'b1, 3'd2, 8'h5A, 8'h04});
        end
        checks++;
        if (err8 !== 1'b0) begin
            failures++;
            $display("FAIL direct_no_err got=%b exp=0", err8);
        end
    endtask

    task automatic test_back_pressure();
        ready8 = 1'b0;
        code8[2*8 +: 8] = 8'h11;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs8 !== {1'b1, 3'd2, 8'h5A, 8'h00}) begin
                failures++;
                $display("FAIL backpressure_hold%0d got=%h exp=%h", i, obs8, {1'b1, 3'd2, 8'h5A, 8'h00});
            end
        end
        ready8 = 1'b1;
        step();
        checks++;
        if (obs8 !== {1'b1, 3'd2, 8'h11, 8'h04}) begin
            failures++;
            $display("FAIL backpressure_release got=%h exp=%h", obs8, {1'b1, 3'd2, 8'h11, 8'h04});
        end
        valid8 = 8'h00;
        step();
        checks++;
        if (obs8 !== {1'b0, 3'd2, 8'h11, 8'h00}) begin
            failures++;
            $display("FAIL drain_hold got=%h exp=%h", obs8, {1'b0, 3'd2, 8'h11, 8'h00});
        end
    endtask

    task automatic test_scan_wrap();
        logic [2:0] exp_ch [5];
        logic [7:0] exp_ack [5];
        exp_ch  = '{3'd0, 3'd4, 3'd7, 3'd0, 3'd4};
        exp_ack = '{8'h01, 8'h10, 8'h80, 8'h01, 8'h10};
        code8[0*8 +: 8] = 8'hA0;
        code8[4*8 +: 8] = 8'hA4;
        code8[7*8 +: 8] = 8'hA7;
        mode8 = 1'b1; valid8 = 8'h91; ready8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs8 !== {1'b1, exp_ch[i], {5'h14, exp_ch[i]}, exp_ack[i]}) begin
                failures++;
                $display("FAIL scan_wrap%0d got=%h exp=%h", i, obs8, {1'b1, exp_ch[i], {5'h14, exp_ch[i]}, exp_ack[i]});
            end
        end
    endtask

    task automatic test_scan_idle();
        // pointer now sits at 5
        valid8 = 8'h00;
        step();
        checks++;
        if ({vo8, ack8} !== 9'h000) begin
            failures++;
            $display("FAIL scan_idle_drain got=%h exp=000", {vo8, ack8});
        end
        step();
        checks++;
        if ({vo8, ack8} !== 9'h000) begin
            failures++;
            $display("FAIL scan_idle_quiet got=%h exp=000", {vo8, ack8});
        end
        code8[5*8 +: 8] = 8'hC5;
        valid8 = 8'h20;
        step();
        checks++;
        if (obs8 !== {1'b1, 3'd5, 8'hC5, 8'h20}) begin
            failures++;
            $display("FAIL scan_idle_wake got=%h exp=%h", obs8, {1'b1, 3'd5, 8'hC5, 8'h20});
        end
    endtask

    task automatic test_mode_switch();
        // pointer now 6; re-entering scan must start at ch0, not ch6
        mode8 = 1'b0; valid8 = 8'h00; sel8 = 3'd3;
        step();
        code8[6*8 +: 8] = 8'hC6;
        mode8 = 1'b1; valid8 = 8'h41;
        step();
        checks++;
        if (obs8 !== {1'b1, 3'd0, 8'hA0, 8'h01}) begin
            failures++;
            $display("FAIL mode_switch_restart got=%h exp=%h", obs8, {1'b1, 3'd0, 8'hA0, 8'h01});
        end
        step();
        checks++;
        if (obs8 !== {1'b1, 3'd6, 8'hC6, 8'h40}) begin
            failures++;
            $display("FAIL mode_switch_next got=%h exp=%h", obs8, {1'b1, 3'd6, 8'hC6, 8'h40});
        end
    endtask

    task automatic test_sel_err();
        for (int c = 0; c < 6; c++) code6[c*8 +: 8] = 8'hB0 + 8'(c);
        valid6 = 6'h3F; mode6 = 1'b0; ready6 = 1'b1; sel6 = 3'd1;
        step();
        checks++;
        if ({obs6, err6} !== {1'b1, 3'd1, 8'hB1, 6'h02, 1'b0}) begin
            failures++;
            $display("FAIL sel_ok_capture got=%h exp=%h", {obs6, err6}, {1'b1, 3'd1, 8'hB1, 6'h02, 1'b0});
        end
        sel6 = 3'd7;
        step();
        checks++;
        if ({obs6, err6} !== {1'b0, 3'd1, 8'hB1, 6'h00, 1'b1}) begin
            failures++;
            $display("FAIL sel_err7 got=%h exp=%h", {obs6, err6}, {1'b0, 3'd1, 8'hB1, 6'h00, 1'b1});
        end
        sel6 = 3'd6;
        step();
        checks++;
        if ({vo6, ack6, err6} !== {1'b0, 6'h00, 1'b1}) begin
            failures++;
            $display("FAIL sel_err6 got=%h exp=%h", {vo6, ack6, err6}, {1'b0, 6'h00, 1'b1});
        end
        sel6 = 3'd5;
        step();
        checks++;
        if ({obs6, err6} !== {1'b1, 3'd5, 8'hB5, 6'h20, 1'b0}) begin
            failures++;
            $display("FAIL sel_last_ok got=%h exp=%h", {obs6, err6}, {1'b1, 3'd5, 8'hB5, 6'h20, 1'b0});
        end
    endtask

    task automatic test_scan_wrap6();
        // ch5 is the last channel; the pointer must wrap to ch0 after it
        mode6 = 1'b1; sel6 = 3'd7; valid6 = 6'h21;
        step();
        checks++;
        if ({ch6, ack6, err6} !== {3'd0, 6'h01, 1'b0}) begin
            failures++;
            $display("FAIL wrap6_a got=%h exp=%h", {ch6, ack6, err6}, {3'd0, 6'h01, 1'b0});
        end
        step();
        checks++;
        if ({ch6, ack6} !== {3'd5, 6'h20}) begin
            failures++;
            $display("FAIL wrap6_b got=%h exp=%h", {ch6, ack6}, {3'd5, 6'h20});
        end
        step();
        checks++;
        if ({ch6, ack6} !== {3'd0, 6'h01}) begin
            failures++;
            $display("FAIL wrap6_c got=%h exp=%h", {ch6, ack6}, {3'd0, 6'h01});
        end
    endtask

    task automatic test_reset_mid();
        code8[0*8 +: 8] = 8'h07;
        mode8 = 1'b1; valid8 = 8'h91; ready8 = 1'b1;
        step();
        checks++;
        if (vo8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got=%b exp=1", vo8);
        end
        i_rst_n = 1'b0;
        #2;
        checks++;
        if ({obs8, err8} !== 21'h0) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=0", {obs8, err8});
        end
        i_rst_n = 1'b1;
        step();
        checks++;
        if (obs8 !== {1'b1, 3'd0, 8'h07, 8'h01}) begin
            failures++;
            $display("FAIL reset_mid_restart got=%h exp=%h", obs8, {1'b1, 3'd0, 8'h07, 8'h01});
        end
`ifdef MUX_N_1_SCAN_PARITY_EN
        checks++;
        if (par8 !== 1'b1) begin
            failures++;
            $display("FAIL parity_07 got=%b exp=1", par8);
        end
        ready8 = 1'b0;
        code8[4*8 +: 8] = 8'hA4;
        step();
        checks++;
        if (par8 !== 1'b1) begin
            failures++;
            $display("FAIL parity_hold got=%b exp=1", par8);
        end
        ready8 = 1'b1;
        step();
        checks++;
        if ({ch8, par8} !== {3'd4, 1'b1}) begin
            failures++;
            $display("FAIL parity_a4 got=%h exp=%h", {ch8, par8}, {3'd4, 1'b1});
        end
        code8[7*8 +: 8] = 8'h03;
        step();
        checks++;
        if ({ch8, par8} !== {3'd7, 1'b0}) begin
            failures++;
            $display("FAIL parity_03 got=%h exp=%h", {ch8, par8}, {3'd7, 1'b0});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_direct();
        test_back_pressure();
        test_scan_wrap();
        test_scan_idle();
        test_mode_switch();
        test_sel_err();
        test_scan_wrap6();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_n_1_scan.md
Name: mux_n_1_scan

Overview:
Parametrised, registered N-to-1 multiplexer; successor to the fixed 8:1 combinational mux. Selects one of N_CH data channels by either an explicit select code (direct mode) or an internal round-robin scan pointer that skips idle channels (scan mode). The output is registered behind a valid/ready handshake, with one-hot acknowledge back to the sources. It sits between multi-channel sources and a single downstream consumer in the datapath.

Parameters:
N_CH, 8, number of input channels (2..64)
SEL_W, 3, select/pointer width; must satisfy 2**SEL_W >= N_CH
DATA_W, 8, bits per channel

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_code  in  N_CH*DATA_W  channel data, channel k at bits [k*DATA_W +: DATA_W]
i_valid  in  N_CH  per-channel data valid
i_mode  in  1  0 = direct select, 1 = round-robin scan
i_sel_code  in  SEL_W  channel select, used in direct mode only
i_ready  in  1  downstream ready
o_f  out  DATA_W  registered selected data
o_valid  out  1  o_f/o_ch hold a captured word
o_ch  out  SEL_W  index of the channel captured into o_f
o_ack  out  N_CH  one-hot, one-cycle pulse: channel k's word was captured
o_sel_err  out  1  registered: direct mode with i_sel_code >= N_CH

Behaviour:
- Reset (async assert, synchronous release on i_clk): o_f=0, o_valid=0, o_ch=0, o_ack=0, o_sel_err=0, scan pointer ptr=0, mode_q=0.
- space = !o_valid || i_ready. Capture happens only when space=1 and a candidate channel exists.
- Direct mode (i_mode=0):
  - Candidate = i_sel_code, provided i_sel_code < N_CH and i_valid[i_sel_code]=1.
  - If i_sel_code >= N_CH: no capture; o_sel_err=1 next cycle. Otherwise o_sel_err=0 next cycle.
- Scan mode (i_mode=1):
  - Candidate = first k with i_valid[k]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - On capture: ptr <= k+1, wrapping N_CH-1 -> 0.
  - With no valid channel: no capture, ptr unchanged.
  - o_sel_err is 0 throughout scan mode.
- Mode switch:
  - mode_q registers i_mode.
  - On the cycle where i_mode=1 and mode_q=0, the search starts from ptr=0 (the pointer is treated as 0 that cycle).
  - i_mode is sampled every cycle. No other state is disturbed by a switch.
- Capture at edge: o_f <= selected data, o_ch <= k, o_valid <= 1, o_ack <= one-hot(k). Latency is 1 cycle from input to o_valid.
- o_ack is 0 on every cycle without a capture. A source must treat o_ack[k] as consumption of its current word.
- No capture with o_valid && i_ready: o_valid <= 0. o_f and o_ch hold their last values.
- o_valid && !i_ready: o_f, o_ch and o_valid are held stable, and no capture occurs (back-pressure).
- Simultaneous drain and capture (o_valid && i_ready && candidate): the new word replaces the old one, o_valid stays 1, giving full throughput of 1 word per cycle.
- Reset mid-transfer: any held word is discarded and all outputs return to reset values immediately.

Optional Feature:
MUX_N_1_SCAN_PARITY_EN
- Defined: adds output port o_parity (1 bit) = XOR of the DATA_W data bits being captured, registered alongside o_f. It resets to 0 and holds with o_f under back-pressure.
- Not defined: port absent; no parity logic.

Test Plan:
- Direct, N_CH=8, i_code ch2=0x5A, i_valid=0x04, i_sel_code=2, i_ready=1 -> next cycle o_f=0x5A, o_ch=2, o_valid=1, o_ack=0x04; the cycle after, o_ack=0x00.
- Back-pressure: o_valid=1 (o_f=0x5A), i_ready=0 for 3 cycles while ch2 changes to 0x11 -> o_f stays 0x5A, o_ack=0. Then raise i_ready -> o_f=0x11 next cycle.
- Scan skip/wrap: i_mode=1, i_valid=0x91 (ch0, ch4, ch7), i_ready=1 -> o_ch sequence 0, 4, 7, 0, 4, ... across consecutive cycles; o_ack=0x01, 0x10, 0x80, ...
- Scan idle: i_valid=0x00 -> o_valid falls the cycle after the last capture and o_ack stays 0. Then i_valid=0x20 -> o_ch=5 one cycle later.
- Select error, with N_CH=6 and SEL_W=3: i_mode=0, i_sel_code=7 -> o_sel_err=1 next cycle, no o_ack, o_valid drains. i_sel_code=1 -> o_sel_err=0.
- Async reset asserted mid-stream with o_valid=1 -> o_valid, o_f, o_ack and o_ch are 0 before the next i_clk edge. After release, scan restarts from ch0. With MUX_N_1_SCAN_PARITY_EN, data 0x07 gives o_parity=1.
